// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and forwarding-select generation for a 5-stage MIPS pipeline.
// Keeps shadow E/M/W metadata (valid, dst, tnew, src) and derives, combinationally from that
// state and the D-stage inputs, the F/D stall request and the five forwarding-mux selects.
// Optional feature macro: HAZARD_STALL_STATS_EN enables a saturating stall-cycle counter;
// when undefined the counter output is tied to zero and no counter flops are built.
module hazard_ctrl #(
    parameter int unsigned STATS_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               d_valid_i,
    input  logic [4:0]         d_rs_i,
    input  logic [4:0]         d_rt_i,
    input  logic [1:0]         d_tuse_rs_i,
    input  logic [1:0]         d_tuse_rt_i,
    input  logic [4:0]         d_dst_i,
    input  logic [1:0]         d_tnew_i,
    input  logic [1:0]         d_src_i,
    output logic               stall_o,
    output logic [2:0]         cd_rs_o,
    output logic [2:0]         cd_rt_o,
    output logic [2:0]         ce_a_o,
    output logic [2:0]         ce_b_o,
    output logic [2:0]         cm_i_o,
    output logic [1:0]         m_src_o,
    output logic [1:0]         w_src_o,
    output logic [STATS_W-1:0] stall_count_o
);

    localparam logic [2:0] SelReg = 3'b000;
    localparam logic [2:0] SelM   = 3'b001;
    localparam logic [2:0] SelW   = 3'b010;

    // Shadow pipeline state. W's tnew is never consulted (a W occupant is always ready),
    // so it is not stored.
    logic       e_valid_q, e_valid_d;
    logic [4:0] e_dst_q,   e_dst_d;
    logic [1:0] e_tnew_q,  e_tnew_d;
    logic [1:0] e_src_q,   e_src_d;
    logic [4:0] e_rs_q,    e_rs_d;
    logic [4:0] e_rt_q,    e_rt_d;
    logic       m_valid_q, m_valid_d;
    logic [4:0] m_dst_q,   m_dst_d;
    logic [1:0] m_tnew_q,  m_tnew_d;
    logic [1:0] m_src_q,   m_src_d;
    logic [4:0] m_rt_q,    m_rt_d;
    logic       w_valid_q, w_valid_d;
    logic [4:0] w_dst_q,   w_dst_d;
    logic [1:0] w_src_q,   w_src_d;

    // Stage occupant produces register r; $0 never matches.
    function automatic logic hit(input logic v, input logic [4:0] dst, input logic [4:0] r);
        return v && (dst == r) && (r != 5'd0);
    endfunction

    // M wins over W because it holds the younger value; M only forwards once its result is ready.
    function automatic logic [2:0] fwd_sel(input logic m_hit, input logic m_ready,
                                           input logic w_hit);
        if (m_hit && m_ready) begin
            return SelM;
        end else if (w_hit) begin
            return SelW;
        end else begin
            return SelReg;
        end
    endfunction

    // Stall when a D source would be consumed before the producer's value can reach it.
    // There is no E->D path, so an E producer always blocks a D-stage (tuse 0) consumer.
    function automatic logic src_stall(input logic e_hit, input logic [1:0] e_tnew,
                                       input logic m_hit, input logic [1:0] m_tnew,
                                       input logic [1:0] tuse);
        logic e_blk;
        logic m_blk;
        e_blk = e_hit && ((e_tnew > tuse) || (tuse == 2'd0));
        m_blk = m_hit && (m_tnew > tuse);
        return (tuse != 2'd3) && (e_blk || m_blk);
    endfunction

    logic stall;

    // Hazard detection and forwarding selects from shadow state and D inputs.
    always_comb begin
        logic rs_stall;
        logic rt_stall;
        rs_stall = src_stall(hit(e_valid_q, e_dst_q, d_rs_i), e_tnew_q,
                             hit(m_valid_q, m_dst_q, d_rs_i), m_tnew_q, d_tuse_rs_i);
        rt_stall = src_stall(hit(e_valid_q, e_dst_q, d_rt_i), e_tnew_q,
                             hit(m_valid_q, m_dst_q, d_rt_i), m_tnew_q, d_tuse_rt_i);
        stall    = d_valid_i && (rs_stall || rt_stall);

        cd_rs_o = fwd_sel(hit(m_valid_q, m_dst_q, d_rs_i), m_tnew_q == 2'd0,
                          hit(w_valid_q, w_dst_q, d_rs_i));
        cd_rt_o = fwd_sel(hit(m_valid_q, m_dst_q, d_rt_i), m_tnew_q == 2'd0,
                          hit(w_valid_q, w_dst_q, d_rt_i));
        ce_a_o  = fwd_sel(hit(m_valid_q, m_dst_q, e_rs_q), m_tnew_q == 2'd0,
                          hit(w_valid_q, w_dst_q, e_rs_q));
        ce_b_o  = fwd_sel(hit(m_valid_q, m_dst_q, e_rt_q), m_tnew_q == 2'd0,
                          hit(w_valid_q, w_dst_q, e_rt_q));
        cm_i_o  = (m_valid_q && hit(w_valid_q, w_dst_q, m_rt_q)) ? SelM : SelReg;
    end

    assign stall_o = stall;
    assign m_src_o = m_src_q;
    assign w_src_o = w_src_q;

    // Next shadow state: advance W<-M<-E, load E from D or insert a bubble.
    always_comb begin
        w_valid_d = m_valid_q;
        w_dst_d   = m_dst_q;
        w_src_d   = m_src_q;
        m_valid_d = e_valid_q;
        m_dst_d   = e_dst_q;
        m_tnew_d  = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        m_src_d   = e_src_q;
        m_rt_d    = e_rt_q;
        e_valid_d = 1'b0;
        e_dst_d   = 5'd0;
        e_tnew_d  = 2'd0;
        e_src_d   = 2'd0;
        e_rs_d    = 5'd0;
        e_rt_d    = 5'd0;
        if (d_valid_i && !stall) begin
            e_valid_d = 1'b1;
            e_dst_d   = d_dst_i;
            e_tnew_d  = d_tnew_i;
            e_src_d   = d_src_i;
            e_rs_d    = d_rs_i;
            e_rt_d    = d_rt_i;
        end
    end

    // Shadow pipeline registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e_valid_q <= 1'b0;
            e_dst_q   <= 5'd0;
            e_tnew_q  <= 2'd0;
            e_src_q   <= 2'd0;
            e_rs_q    <= 5'd0;
            e_rt_q    <= 5'd0;
            m_valid_q <= 1'b0;
            m_dst_q   <= 5'd0;
            m_tnew_q  <= 2'd0;
            m_src_q   <= 2'd0;
            m_rt_q    <= 5'd0;
            w_valid_q <= 1'b0;
            w_dst_q   <= 5'd0;
            w_src_q   <= 2'd0;
        end else begin
            e_valid_q <= e_valid_d;
            e_dst_q   <= e_dst_d;
            e_tnew_q  <= e_tnew_d;
            e_src_q   <= e_src_d;
            e_rs_q    <= e_rs_d;
            e_rt_q    <= e_rt_d;
            m_valid_q <= m_valid_d;
            m_dst_q   <= m_dst_d;
            m_tnew_q  <= m_tnew_d;
            m_src_q   <= m_src_d;
            m_rt_q    <= m_rt_d;
            w_valid_q <= w_valid_d;
            w_dst_q   <= w_dst_d;
            w_src_q   <= w_src_d;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [STATS_W-1:0] stall_count_q, stall_count_d;

    // Saturating count of stalled cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {STATS_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count_o = stall_count_q;
`else
    assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: reset values, ALU/load/branch/jal/store
// forwarding and stall scenarios, $0 handling, invalid D, and reset during a stall.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        d_valid = 1'b0;
    logic [4:0]  d_rs = 5'd0;
    logic [4:0]  d_rt = 5'd0;
    logic [1:0]  d_tuse_rs = 2'd3;
    logic [1:0]  d_tuse_rt = 2'd3;
    logic [4:0]  d_dst = 5'd0;
    logic [1:0]  d_tnew = 2'd0;
    logic [1:0]  d_src = 2'd0;
    logic        stall;
    logic [2:0]  cd_rs, cd_rt, ce_a, ce_b, cm_i;
    logic [1:0]  m_src, w_src;
    logic [31:0] stall_count;

    int total = 0;
    int bad = 0;

    hazard_ctrl #(.STATS_W(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .d_valid_i     (d_valid),
        .d_rs_i        (d_rs),
        .d_rt_i        (d_rt),
        .d_tuse_rs_i   (d_tuse_rs),
        .d_tuse_rt_i   (d_tuse_rt),
        .d_dst_i       (d_dst),
        .d_tnew_i      (d_tnew),
        .d_src_i       (d_src),
        .stall_o       (stall),
        .cd_rs_o       (cd_rs),
        .cd_rt_o       (cd_rt),
        .ce_a_o        (ce_a),
        .ce_b_o        (ce_b),
        .cm_i_o        (cm_i),
        .m_src_o       (m_src),
        .w_src_o       (w_src),
        .stall_count_o (stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input int v, input int rs, input int rt, input int trs, input int trt,
                         input int dst, input int tnew, input int src);
        d_valid   = v[0];
        d_rs      = 5'(rs);
        d_rt      = 5'(rt);
        d_tuse_rs = 2'(trs);
        d_tuse_rt = 2'(trt);
        d_dst     = 5'(dst);
        d_tnew    = 2'(tnew);
        d_src     = 2'(src);
        #1;
    endtask

    task automatic nop();
        set_d(0, 0, 0, 3, 3, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        tick();
        tick();
        tick();
    endtask

    initial begin
        // Reset with a busy-looking D instruction applied.
        set_d(1, 3, 3, 0, 0, 3, 1, 0);
        tick();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_cd_rs", 32'(cd_rs), 0);
        chk("rst_ce_a", 32'(ce_a), 0);
        chk("rst_cm_i", 32'(cm_i), 0);
        chk("rst_m_src", 32'(m_src), 0);
        chk("rst_count", stall_count, 0);
        nop();
        rst_n = 1'b1;
        tick();

        // addu $3 ; subu rs=$3 ; or rs=$3
        set_d(1, 1, 2, 1, 1, 3, 1, 0);
        chk("addu_nostall", 32'(stall), 0);
        tick();
        set_d(1, 3, 4, 1, 1, 6, 1, 0);
        chk("subu_nostall", 32'(stall), 0);
        tick();
        set_d(1, 3, 0, 1, 1, 8, 1, 0);
        chk("subu_ce_a_m", 32'(ce_a), 1);
        chk("or_cd_rs_m", 32'(cd_rs), 1);
        chk("addu_m_src", 32'(m_src), 0);
        tick();
        nop();
        chk("or_ce_a_w", 32'(ce_a), 2);
        chk("or_ce_b_r0", 32'(ce_b), 0);
        drain();

        // lw $5 ; addu rt=$5 -> one stall cycle, then W forward
        set_d(1, 1, 0, 1, 3, 5, 2, 1);
        chk("lw_nostall", 32'(stall), 0);
        tick();
        set_d(1, 1, 5, 1, 1, 9, 1, 0);
        chk("lwuse_stall1", 32'(stall), 1);
        tick();
        chk("lwuse_stall_end", 32'(stall), 0);
        chk("lw_m_src", 32'(m_src), 1);
        tick();
        nop();
        chk("lwuse_ce_b_w", 32'(ce_b), 2);
        chk("lwuse_ce_a", 32'(ce_a), 0);
        chk("lw_w_src", 32'(w_src), 1);
        drain();

        // lw $5 ; beq rs=$5 -> two stall cycles, then W forward in D
        set_d(1, 1, 0, 1, 3, 5, 2, 1);
        tick();
        set_d(1, 5, 0, 0, 0, 0, 0, 0);
        chk("beq_stall1", 32'(stall), 1);
        tick();
        chk("beq_stall2", 32'(stall), 1);
        chk("beq_cd_rs_notready", 32'(cd_rs), 0);
        tick();
        chk("beq_stall_end", 32'(stall), 0);
        chk("beq_cd_rs_w", 32'(cd_rs), 2);
        drain();

        // jal ; jr $31 -> one stall cycle, then M forward of PC+8
        set_d(1, 0, 0, 3, 3, 31, 0, 2);
        chk("jal_nostall", 32'(stall), 0);
        tick();
        set_d(1, 31, 0, 0, 3, 0, 0, 0);
        chk("jr_stall1", 32'(stall), 1);
        tick();
        chk("jr_stall_end", 32'(stall), 0);
        chk("jr_cd_rs_m", 32'(cd_rs), 1);
        chk("jal_m_src", 32'(m_src), 2);
        drain();
`ifdef HAZARD_STALL_STATS_EN
        chk("count_so_far", stall_count, 4);
`else
        chk("count_off", stall_count, 0);
`endif

        // lw $7 ; sw rt=$7 -> no stall, store data from W at M
        set_d(1, 1, 0, 1, 3, 7, 2, 1);
        tick();
        set_d(1, 2, 7, 1, 2, 0, 1, 0);
        chk("sw_nostall", 32'(stall), 0);
        tick();
        nop();
        chk("sw_ce_b_notready", 32'(ce_b), 0);
        tick();
        chk("sw_cm_i_w", 32'(cm_i), 1);
        drain();

        // $0 as a destination and as sources
        set_d(1, 1, 0, 1, 3, 0, 2, 1);
        tick();
        set_d(1, 0, 0, 0, 0, 0, 1, 0);
        chk("r0_nostall", 32'(stall), 0);
        tick();
        nop();
        chk("r0_ce_a", 32'(ce_a), 0);
        chk("r0_ce_b", 32'(ce_b), 0);
        tick();
        chk("r0_cm_i", 32'(cm_i), 0);
        drain();

        // addu $3 ; lw $5 ; then D reads $5 (branch) and $3
        set_d(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        set_d(1, 1, 0, 1, 3, 5, 2, 1);
        tick();
        set_d(0, 5, 3, 0, 0, 0, 0, 0);
        chk("dinvalid_nostall", 32'(stall), 0);
        set_d(1, 5, 3, 0, 0, 0, 0, 0);
        chk("pre_rst_stall", 32'(stall), 1);
        chk("pre_rst_cd_rt_m", 32'(cd_rt), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall), 0);
        chk("midrst_cd_rt", 32'(cd_rt), 0);
        chk("midrst_m_src", 32'(m_src), 0);
        chk("midrst_count", stall_count, 0);
        tick();
        nop();
        rst_n = 1'b1;
        tick();

        // Three stall cycles for the counter: lw/beq (2) then jal/jr (1)
        set_d(1, 1, 0, 1, 3, 5, 2, 1);
        tick();
        set_d(1, 5, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        drain();
        set_d(1, 0, 0, 3, 3, 31, 0, 2);
        tick();
        set_d(1, 31, 0, 0, 3, 0, 0, 0);
        tick();
`ifdef HAZARD_STALL_STATS_EN
        chk("count_three", stall_count, 3);
`else
        chk("count_three_off", stall_count, 0);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
